// File: rtl/apb_pkg.sv
// Shared constants for the APB requester: FSM encodings, completer address map
// and the access timeout limit used when APB_TIMEOUT_EN is defined.
package apb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Slot 0 = interrupt controller, slot 1 = timer; spare slots can never match.
    localparam int MAX_SLAVE = 4;
    localparam logic [31:0] SLAVE_BASE [MAX_SLAVE] = '{
        32'h2000_0000, 32'h2000_1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF
    };
    localparam logic [31:0] SLAVE_MASK [MAX_SLAVE] = '{
        32'hFFFF_FFF8, 32'hFFFF_F000, 32'h0000_0000, 32'h0000_0000
    };

    localparam int unsigned TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_decode.sv
// Address decoder: one-hot completer select plus hit flag. Overlapping windows
// resolve to the lowest slave index.
module apb_decode
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NSLAVE     = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NSLAVE-1:0]     sel,
    output logic                  hit
);

    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (!hit && ((addr & ADDR_WIDTH'(SLAVE_MASK[i])) == ADDR_WIDTH'(SLAVE_BASE[i]))) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_requester.sv
// APB requester: single CPU load/store -> APB SETUP/ACCESS transfer with
// registered outputs. Optional access timeout under macro APB_TIMEOUT_EN.
module apb_requester
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NSLAVE     = 2
) (
    input  logic                         pclk,
    input  logic                         presetn,
    input  logic                         cpu_req,
    input  logic [ADDR_WIDTH-1:0]        cpu_addr,
    input  logic [DATA_WIDTH-1:0]        cpu_wdata,
    input  logic [3:0]                   cpu_wstrb,
    input  logic                         cpu_we,
    output logic                         cpu_ready,
    output logic [DATA_WIDTH-1:0]        cpu_rdata,
    output logic                         cpu_err,
    output logic [ADDR_WIDTH-1:0]        paddr,
    output logic [DATA_WIDTH-1:0]        pdata,
    output logic [3:0]                   pstb,
    output logic                         pwrite,
    output logic [NSLAVE-1:0]            psel,
    output logic                         penable,
    input  logic [NSLAVE*DATA_WIDTH-1:0] prdata,
    input  logic [NSLAVE-1:0]            pready,
    input  logic [NSLAVE-1:0]            perr,
    output logic                         bus_err,
    output logic [1:0]                   dbg_state
);

    // Handshake: cpu_req is sampled only in IDLE; cpu_ready is a one-cycle pulse
    // carrying cpu_rdata/cpu_err. APB side: pready[i] is honoured only while
    // psel[i] && penable, and all APB outputs hold stable until it is seen.

    logic [1:0]            state;
    logic [NSLAVE-1:0]     dec_sel;
    logic                  dec_hit;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  sel_ready;
    logic                  sel_err;
    logic                  to_hit;

    apb_decode #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .NSLAVE     (NSLAVE)
    ) u_decode (
        .addr (cpu_addr),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // psel is one-hot, so OR-ing the gated lanes selects the active completer.
    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NSLAVE; i++) begin
            if (psel[i]) begin
                sel_rdata = sel_rdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_ready = |(pready & psel);
    assign sel_err   = |(perr & psel);
    assign dbg_state = state;

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] to_cnt;

    assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            to_cnt <= '0;
        end else if (state == ST_IDLE && cpu_req && dec_hit) begin
            to_cnt <= '0;
        end else if (state == ST_ACCESS && !to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state     <= ST_IDLE;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            paddr     <= '0;
            pdata     <= '0;
            pstb      <= '0;
            pwrite    <= 1'b0;
            psel      <= '0;
            penable   <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            bus_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (dec_hit) begin
                            paddr  <= cpu_addr;
                            pdata  <= cpu_wdata;
                            pstb   <= cpu_wstrb;
                            pwrite <= cpu_we;
                            psel   <= dec_sel;
                            state  <= ST_SETUP;
                        end else begin
                            // Unmapped address: answer immediately, bus stays quiet.
                            cpu_ready <= 1'b1;
                            cpu_rdata <= '0;
                            cpu_err   <= 1'b1;
                            bus_err   <= 1'b1;
                            state     <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    penable <= 1'b1;
                    state   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= pwrite ? '0 : sel_rdata;
                        cpu_err   <= sel_err;
                        bus_err   <= sel_err;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= ST_RESP;
                    end else if (to_hit) begin
                        cpu_ready <= 1'b1;
                        cpu_rdata <= '0;
                        cpu_err   <= 1'b1;
                        bus_err   <= 1'b1;
                        psel      <= '0;
                        penable   <= 1'b0;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Self-checking bench for apb_requester: directed transfers, unmapped access,
// wait states with error, reset mid-access, random back-to-back traffic, timeout.
module tb_apb_requester;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 2;

    logic              pclk = 1'b0;
    logic              presetn;
    logic              cpu_req;
    logic [AW-1:0]     cpu_addr;
    logic [DW-1:0]     cpu_wdata;
    logic [3:0]        cpu_wstrb;
    logic              cpu_we;
    logic              cpu_ready;
    logic [DW-1:0]     cpu_rdata;
    logic              cpu_err;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pdata;
    logic [3:0]        pstb;
    logic              pwrite;
    logic [NS-1:0]     psel;
    logic              penable;
    logic [NS*DW-1:0]  prdata;
    logic [NS-1:0]     pready;
    logic [NS-1:0]     perr;
    logic              bus_err;
    logic [1:0]        dbg_state;

    int errors = 0;
    int checks = 0;
    logic [DW:0] exp_q[$];

    always #5 pclk = ~pclk;

    apb_requester #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NSLAVE(NS)) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_wstrb (cpu_wstrb),
        .cpu_we    (cpu_we),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .cpu_err   (cpu_err),
        .paddr     (paddr),
        .pdata     (pdata),
        .pstb      (pstb),
        .pwrite    (pwrite),
        .psel      (psel),
        .penable   (penable),
        .prdata    (prdata),
        .pready    (pready),
        .perr      (perr),
        .bus_err   (bus_err),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, cpu_ready, 0);
        check({tag, "_psel"}, psel, 0);
        check({tag, "_penable"}, penable, 0);
        check({tag, "_paddr"}, paddr, 0);
        check({tag, "_pdata"}, pdata, 0);
        check({tag, "_buserr"}, bus_err, 0);
        check({tag, "_rdata"}, cpu_rdata, 0);
        check({tag, "_state"}, dbg_state, 0);
    endtask

    // slv < 0: unmapped; waits < 0: completer never ready; exp_lat == 0: no completion expected.
    task automatic do_req(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input logic we,
                          input logic [3:0] wstrb, input int slv, input int waits,
                          input logic [DW-1:0] rd, input logic er, input int exp_lat, input int budget);
        logic          exp_err;
        logic [DW-1:0] exp_rd;
        logic [AW+DW+4+NS:0] snap;
        int cyc, pen, bus, psel_cyc, stab_bad;
        logic seen;
        if (slv < 0 || waits < 0) begin
            exp_err = 1'b1;
            exp_rd  = '0;
        end else begin
            exp_err = er;
            exp_rd  = we ? '0 : rd;
        end
        if (exp_lat > 0) exp_q.push_back({exp_err, exp_rd});
        pen = 0; bus = 0; psel_cyc = 0; stab_bad = 0; seen = 1'b0; cyc = 0; snap = '0;

        @(negedge pclk);
        cpu_req   = 1'b1;
        cpu_addr  = addr;
        cpu_wdata = wdata;
        cpu_we    = we;
        cpu_wstrb = wstrb;
        prdata    = {$urandom, $urandom};
        pready    = '1;
        perr      = '1;
        if (slv >= 0) begin
            prdata[slv*DW +: DW] = rd;
            pready[slv] = 1'b0;
            perr[slv]   = er;
        end
        @(posedge pclk);
        #1;
        cpu_req   = 1'b0;
        cpu_addr  = $urandom;
        cpu_wdata = $urandom;
        cpu_we    = ~we;
        cpu_wstrb = 4'($urandom);

        while (cyc < budget && !seen) begin
            cyc++;
            @(negedge pclk);
            if (psel != 0) psel_cyc++;
            if (cyc == 1 && slv >= 0) begin
                check("setup_psel", psel, NS'(1) << slv);
                check("setup_penable", penable, 0);
                check("setup_paddr", paddr, addr);
                check("setup_pdata", pdata, wdata);
                check("setup_pstb", pstb, wstrb);
                check("setup_pwrite", pwrite, we);
                snap = {paddr, pdata, pstb, pwrite, psel};
            end
            if (penable) begin
                pen++;
                if ({paddr, pdata, pstb, pwrite, psel} !== snap) stab_bad++;
            end
            if (bus_err) bus++;
            if (cpu_ready) begin
                seen = 1'b1;
                check("latency", cyc, exp_lat);
                check("bus_err_with_ready", bus_err, cpu_err);
                if (exp_q.size() == 0) check("sb_unexpected", 1, 0);
                else check("sb_resp", {cpu_err, cpu_rdata}, exp_q.pop_front());
            end
            if (slv >= 0) pready[slv] = penable && (waits >= 0) && (pen > waits);
        end

        if (exp_lat > 0) begin
            check("completed", seen, 1);
            @(negedge pclk);
            check("ready_pulse_1cyc", cpu_ready, 0);
            if (bus_err) bus++;
            check("bus_err_pulses", bus, exp_err);
            if (slv >= 0 && waits >= 0) check("penable_cycles", pen, waits + 1);
            if (slv >= 0) check("apb_stable", stab_bad, 0);
            if (slv < 0) check("miss_no_psel", psel_cyc, 0);
        end else begin
            check("no_completion", seen, 0);
        end
        pready = '0;
        perr   = '0;
    endtask

    initial begin
        presetn = 1'b0; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        cpu_wstrb = '0; cpu_we = 1'b0; prdata = '0; pready = '0; perr = '0;
        repeat (3) @(negedge pclk);
        check_idle_outputs("reset");
        presetn = 1'b1;

        // Store to interrupt controller, one wait state.
        do_req(32'h2000_0004, 32'h0000_0003, 1'b1, 4'hF, 0, 1, 32'hDEAD_BEEF, 1'b0, 4, 50);
        // Zero-wait load.
        do_req(32'h2000_0000, 32'hA5A5_0000, 1'b0, 4'h3, 0, 0, 32'h0000_0002, 1'b0, 3, 50);
        // Unmapped, and just past the 8-byte slave 0 window.
        do_req(32'h9000_0000, 32'h0, 1'b0, 4'h0, -1, 0, 32'h1234_5678, 1'b0, 1, 50);
        do_req(32'h2000_0008, 32'h0, 1'b0, 4'h0, -1, 0, 32'h1234_5678, 1'b0, 1, 50);
        // Store to timer with 5 waits and error.
        do_req(32'h2000_1010, 32'hCAFE_F00D, 1'b1, 4'h5, 1, 5, 32'h0, 1'b1, 8, 50);

        // Reset dropped in ACCESS.
        do_req(32'h2000_1000, 32'h0, 1'b0, 4'h0, 1, -1, 32'h0, 1'b0, 0, 5);
        check("pre_reset_state", dbg_state, 2);
        #2 presetn = 1'b0;
        #1 check_idle_outputs("async_reset");
        repeat (2) @(negedge pclk);
        check("reset_no_ready", cpu_ready, 0);
        presetn = 1'b1;
        do_req(32'h2000_1004, 32'h0, 1'b0, 4'h0, 1, 2, 32'h5555_AAAA, 1'b0, 5, 50);

        // Random back-to-back traffic.
        for (int i = 0; i < 8; i++) begin
            int s = $urandom_range(0, 1);
            int w = $urandom_range(0, 3);
            logic [AW-1:0] a = (s == 0) ? (32'h2000_0000 | AW'($urandom_range(0, 7)))
                                        : (32'h2000_1000 | AW'($urandom_range(0, 4095)));
            do_req(a, $urandom, 1'($urandom), 4'($urandom), s, w, $urandom, 1'($urandom), 3 + w, 50);
        end

`ifdef APB_TIMEOUT_EN
        do_req(32'h2000_0000, 32'h0, 1'b0, 4'h0, 0, -1, 32'h0, 1'b0, 257, 400);
`else
        do_req(32'h2000_0000, 32'h0, 1'b0, 4'h0, 0, -1, 32'h0, 1'b0, 0, 1000);
        check("still_waiting", dbg_state, 2);
        presetn = 1'b0;
        @(negedge pclk);
        presetn = 1'b1;
`endif
        do_req(32'h2000_0000, 32'h0, 1'b0, 4'hF, 0, 0, 32'h0BAD_F00D, 1'b0, 3, 50);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
